axis_frame_pattern_gen: RTL and testbench

// Parametrised AXI4-Stream test-frame source for DMA/capture bring-up.

---
 rtl/axis_frame_pattern_gen_if.sv | 27 ++
 rtl/axis_frame_pattern_gen.sv | 156 +++++++++++++++
 tb/tb_axis_frame_pattern_gen.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_frame_pattern_gen_if.sv
// Stream + write-length descriptor bundle between the pattern generator and the DMA write path.
interface axis_frame_pattern_gen_if #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1,
  parameter int LEN_WIDTH  = 11
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;
  logic [LEN_WIDTH-1:0]  desc_len;
  logic                  desc_valid;
  logic                  desc_ready;

  modport master (
    output tdata, tkeep, tvalid, tlast, tuser, desc_len, desc_valid,
    input  tready, desc_ready
  );

  modport slave (
    input  tdata, tkeep, tvalid, tlast, tuser, desc_len, desc_valid,
    output tready, desc_ready
  );
endinterface

// File: rtl/axis_frame_pattern_gen.sv
// AXI4-Stream test-frame source: announces each frame's byte length on the descriptor
// channel, then streams a counter / fill / counter+sequence pattern of that length.
module axis_frame_pattern_gen #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1,
  parameter int LEN_WIDTH  = 11,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_enable,
  input  logic [1:0]            i_cfg_mode,
  input  logic [7:0]            i_cfg_fill,
  input  logic [LEN_WIDTH-1:0]  i_cfg_min_len,
  input  logic [LEN_WIDTH-1:0]  i_cfg_max_len,
  input  logic [LEN_WIDTH-1:0]  i_cfg_len_step,
  input  logic [CNT_WIDTH-1:0]  i_cfg_frame_limit,
  axis_frame_pattern_gen_if.master m_axis,
  output logic [CNT_WIDTH-1:0]  o_frame_count,
  output logic                  o_busy,
  output logic                  o_done
);
  localparam int OFF_W = LEN_WIDTH + 2;

  typedef enum logic [1:0] {S_IDLE, S_DESC, S_DATA} state_t;

  state_t                r_state, w_state_nxt;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [1:0]            r_mode;
  logic [7:0]            r_fill;
  logic [7:0]            r_fseq;
  logic [OFF_W-1:0]      r_off;
  logic                  r_desc_valid;
  logic                  r_tvalid;
  logic                  r_tlast;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic [KEEP_WIDTH-1:0] r_tkeep;
  logic [CNT_WIDTH-1:0]  r_frame_count;
  logic [CNT_WIDTH-1:0]  r_run_cnt;
  logic                  r_done;

  logic                  w_desc_hs, w_data_hs, w_last_hs, w_limit_hit, w_desc_entry;
  logic [LEN_WIDTH:0]    w_len_sum;
  logic [LEN_WIDTH-1:0]  w_len_cand, w_len_new;
  logic [OFF_W-1:0]      w_beat_off;
  logic [7:0]            w_fseq;
  logic [DATA_WIDTH-1:0] w_tdata;
  logic [KEEP_WIDTH-1:0] w_tkeep;
  logic                  w_tlast;

  assign w_desc_hs   = r_desc_valid && m_axis.desc_ready;
  assign w_data_hs   = r_tvalid && m_axis.tready;
  assign w_last_hs   = w_data_hs && r_tlast;
  // Run counter restarts whenever enable drops, so a re-enabled run honours the limit again.
  assign w_limit_hit = (i_cfg_frame_limit != '0) &&
                       ((r_run_cnt + CNT_WIDTH'(1)) == i_cfg_frame_limit);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (i_enable && !r_done) w_state_nxt = S_DESC;
      S_DESC: if (w_desc_hs) w_state_nxt = S_DATA;
      S_DATA: if (w_last_hs) w_state_nxt = (i_enable && !w_limit_hit) ? S_DESC : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_desc_entry = (w_state_nxt == S_DESC) && (r_state != S_DESC);

  // Starting from IDLE always restarts at min; otherwise step, wrapping on overflow or > max.
  assign w_len_sum  = {1'b0, r_len} + {1'b0, i_cfg_len_step};
  assign w_len_cand = (r_state == S_IDLE || w_len_sum[LEN_WIDTH] ||
                       w_len_sum[LEN_WIDTH-1:0] > i_cfg_max_len)
                      ? i_cfg_min_len : w_len_sum[LEN_WIDTH-1:0];
  assign w_len_new  = (w_len_cand == '0) ? LEN_WIDTH'(1) : w_len_cand;

  assign w_beat_off = w_desc_hs ? '0 : r_off + OFF_W'(KEEP_WIDTH);
  assign w_fseq     = w_desc_hs ? r_frame_count[7:0] : r_fseq;
  assign w_tlast    = (w_beat_off + OFF_W'(KEEP_WIDTH)) >= {2'b00, r_len};

  always_comb begin
    w_tdata = '0;
    w_tkeep = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      if ((w_beat_off + OFF_W'(i)) < {2'b00, r_len}) begin
        w_tkeep[i] = 1'b1;
        case (r_mode)
          2'd1:    w_tdata[i*8 +: 8] = r_fill;
          2'd2:    w_tdata[i*8 +: 8] = w_beat_off[7:0] + 8'(i) + w_fseq;
          default: w_tdata[i*8 +: 8] = w_beat_off[7:0] + 8'(i);
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_len         <= '0;
      r_mode        <= '0;
      r_fill        <= '0;
      r_fseq        <= '0;
      r_off         <= '0;
      r_desc_valid  <= 1'b0;
      r_tvalid      <= 1'b0;
      r_tlast       <= 1'b0;
      r_tdata       <= '0;
      r_tkeep       <= '0;
      r_frame_count <= '0;
      r_run_cnt     <= '0;
      r_done        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_desc_valid <= (w_state_nxt == S_DESC);
      if (w_desc_entry) begin
        r_len  <= w_len_new;
        r_mode <= (i_cfg_mode == 2'd3) ? 2'd0 : i_cfg_mode;
        r_fill <= i_cfg_fill;
      end
      if (w_desc_hs) r_fseq <= r_frame_count[7:0];
      if (w_desc_hs || (w_data_hs && !r_tlast)) begin
        r_off    <= w_beat_off;
        r_tvalid <= 1'b1;
        r_tdata  <= w_tdata;
        r_tkeep  <= w_tkeep;
        r_tlast  <= w_tlast;
      end else if (w_last_hs) begin
        r_tvalid <= 1'b0;
        r_tdata  <= '0;
        r_tkeep  <= '0;
        r_tlast  <= 1'b0;
      end
      if (w_last_hs) begin
        r_frame_count <= r_frame_count + CNT_WIDTH'(1);
        r_run_cnt     <= r_run_cnt + CNT_WIDTH'(1);
        if (w_limit_hit) r_done <= 1'b1;
      end
      if (!i_enable) begin
        r_done    <= 1'b0;
        r_run_cnt <= '0;
      end
    end
  end

  assign m_axis.tdata      = r_tdata;
  assign m_axis.tkeep      = r_tkeep;
  assign m_axis.tvalid     = r_tvalid;
  assign m_axis.tlast      = r_tlast;
  assign m_axis.tuser      = '0;
  assign m_axis.desc_len   = r_len;
  assign m_axis.desc_valid = r_desc_valid;
  assign o_frame_count     = r_frame_count;
  assign o_busy            = (r_state != S_IDLE);
  assign o_done            = r_done;
endmodule

// File: tb/tb_axis_frame_pattern_gen.sv
// Directed bench for axis_frame_pattern_gen: length stepping, tail keep, patterns, stalls, limit, abort.
module tb_axis_frame_pattern_gen;
  localparam int DW = 64, KW = 8, UW = 1, LW = 11, CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [1:0]    cfg_mode;
  logic [7:0]    cfg_fill;
  logic [LW-1:0] cfg_min, cfg_max, cfg_step;
  logic [CW-1:0] cfg_limit;
  logic [CW-1:0] frame_count;
  logic          busy, done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  axis_frame_pattern_gen_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .LEN_WIDTH(LW)) m_if();

  axis_frame_pattern_gen #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW),
                           .LEN_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .clk               (clk),
    .rst               (rst),
    .i_enable          (enable),
    .i_cfg_mode        (cfg_mode),
    .i_cfg_fill        (cfg_fill),
    .i_cfg_min_len     (cfg_min),
    .i_cfg_max_len     (cfg_max),
    .i_cfg_len_step    (cfg_step),
    .i_cfg_frame_limit (cfg_limit),
    .m_axis            (m_if),
    .o_frame_count     (frame_count),
    .o_busy            (busy),
    .o_done            (done)
  );

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    m_if.tready = 1'b1;
    m_if.desc_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_cfg(input logic [1:0] mode, input logic [7:0] fill, input int mn,
                         input int mx, input int st, input int lim);
    cfg_mode = mode; cfg_fill = fill;
    cfg_min = LW'(mn); cfg_max = LW'(mx); cfg_step = LW'(st); cfg_limit = CW'(lim);
  endtask

  // Sink for one frame: accepts the descriptor, then collects beats until tlast.
  // errs counts protocol breaches (beat before descriptor, change while stalled, gap, short keep).
  task automatic get_frame(input int stall_pct, input int drop_at, output int dlen,
                           output int beats, output int bytes, output logic [DW-1:0] first_d,
                           output logic [DW-1:0] last_d, output logic [KW-1:0] last_k,
                           output int errs, output int tmo);
    logic got, rdy, ps, pl;
    logic [DW-1:0] pd;
    logic [KW-1:0] pk;
    dlen = -1; beats = 0; bytes = 0; first_d = '0; last_d = '0; last_k = '0;
    errs = 0; tmo = 0; got = 1'b0; ps = 1'b0; pd = '0; pk = '0; pl = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (m_if.tvalid) errs++;
      m_if.desc_ready = 1'b0;
      if (m_if.desc_valid) begin
        rdy = ($urandom_range(99) >= stall_pct);
        m_if.desc_ready = rdy;
        if (rdy) begin dlen = int'(m_if.desc_len); got = 1'b1; end
      end
    end
    if (!got) begin tmo = 1; return; end
    got = 1'b0;
    for (int i = 0; i < 1000 && !got; i++) begin
      @(negedge clk);
      m_if.desc_ready = 1'b0;
      rdy = ($urandom_range(99) >= stall_pct);
      if (m_if.tvalid) begin
        if (ps && (m_if.tdata !== pd || m_if.tkeep !== pk || m_if.tlast !== pl)) errs++;
        if (rdy) begin
          beats++;
          bytes += $countones(m_if.tkeep);
          if (beats == 1) first_d = m_if.tdata;
          if (!m_if.tlast && m_if.tkeep !== {KW{1'b1}}) errs++;
          if (beats == drop_at) enable = 1'b0;
          if (m_if.tlast) begin last_d = m_if.tdata; last_k = m_if.tkeep; got = 1'b1; end
          ps = 1'b0;
        end else begin
          ps = 1'b1; pd = m_if.tdata; pk = m_if.tkeep; pl = m_if.tlast;
        end
      end else begin
        errs++;
        ps = 1'b0;
      end
      m_if.tready = rdy;
    end
    if (!got) tmo = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; m_if.tready = 1'b1; m_if.desc_ready = 1'b0;
    set_cfg(2'd0, 8'h00, 64, 80, 8, 0);
    repeat (3) @(negedge clk);
    tests++;
    if ({m_if.tvalid, m_if.tlast, m_if.desc_valid, busy, done} !== 5'b0) begin
      fails++; $display("FAIL reset_flags: got %b expected 00000",
                        {m_if.tvalid, m_if.tlast, m_if.desc_valid, busy, done});
    end
    tests++;
    if (frame_count !== '0 || m_if.tkeep !== '0 || m_if.tdata !== '0 || m_if.tuser !== '0) begin
      fails++; $display("FAIL reset_values: count %0d keep %h data %h expected all 0",
                        frame_count, m_if.tkeep, m_if.tdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_len_step();
    int exp_len [4] = '{64, 72, 80, 64};
    int dlen, beats, bytes, errs, tmo;
    logic [DW-1:0] fd, ld;
    logic [KW-1:0] lk;
    do_reset();
    set_cfg(2'd0, 8'h00, 64, 80, 8, 0);
    enable = 1'b1;
    for (int f = 0; f < 4; f++) begin
      get_frame(0, 0, dlen, beats, bytes, fd, ld, lk, errs, tmo);
      tests++;
      if (tmo != 0 || errs != 0 || dlen != exp_len[f] || beats != exp_len[f] / 8 ||
          bytes != exp_len[f] || lk !== 8'hFF) begin
        fails++; $display("FAIL len_step[%0d]: len %0d beats %0d bytes %0d keep %h errs %0d tmo %0d expected len %0d beats %0d keep ff",
                          f, dlen, beats, bytes, lk, errs, tmo, exp_len[f], exp_len[f] / 8);
      end
      if (f == 1) begin
        tests++;
        if (fd !== 64'h0706050403020100 || ld !== 64'h4746454443424140) begin
          fails++; $display("FAIL len_step_data: first %h last %h expected 0706050403020100 / 4746454443424140", fd, ld);
        end
      end
    end
  endtask

  task automatic test_len61();
    int dlen, beats, bytes, errs, tmo;
    logic [DW-1:0] fd, ld;
    logic [KW-1:0] lk;
    do_reset();
    set_cfg(2'd0, 8'h00, 61, 61, 8, 0);
    enable = 1'b1;
    get_frame(0, 0, dlen, beats, bytes, fd, ld, lk, errs, tmo);
    tests++;
    if (tmo != 0 || errs != 0 || dlen != 61 || beats != 8 || bytes != 61) begin
      fails++; $display("FAIL len61_shape: len %0d beats %0d bytes %0d errs %0d tmo %0d expected 61/8/61",
                        dlen, beats, bytes, errs, tmo);
    end
    tests++;
    if (lk !== 8'h1F || ld !== 64'h0000003C3B3A3938) begin
      fails++; $display("FAIL len61_tail: keep %h data %h expected 1f / 0000003c3b3a3938", lk, ld);
    end
  endtask

  task automatic test_stalls();
    int exp_len [3] = '{40, 48, 56};
    int dlen, beats, bytes, errs, tmo;
    logic [DW-1:0] fd, ld;
    logic [KW-1:0] lk;
    do_reset();
    set_cfg(2'd0, 8'h00, 40, 56, 8, 0);
    enable = 1'b1;
    for (int f = 0; f < 3; f++) begin
      get_frame(40, 0, dlen, beats, bytes, fd, ld, lk, errs, tmo);
      tests++;
      if (tmo != 0 || errs != 0 || dlen != exp_len[f] || beats != exp_len[f] / 8 ||
          bytes != exp_len[f] || fd !== 64'h0706050403020100) begin
        fails++; $display("FAIL stalls[%0d]: len %0d beats %0d bytes %0d errs %0d tmo %0d first %h expected len %0d",
                          f, dlen, beats, bytes, errs, tmo, fd, exp_len[f]);
      end
    end
  endtask

  task automatic test_modes();
    int dlen, beats, bytes, errs, tmo;
    logic [DW-1:0] fd, ld;
    logic [KW-1:0] lk;
    do_reset();
    set_cfg(2'd2, 8'h00, 16, 16, 8, 0);
    enable = 1'b1;
    get_frame(0, 0, dlen, beats, bytes, fd, ld, lk, errs, tmo);
    tests++;
    if (tmo != 0 || fd !== 64'h0706050403020100) begin
      fails++; $display("FAIL mode2_f0: first %h tmo %0d expected 0706050403020100", fd, tmo);
    end
    get_frame(0, 0, dlen, beats, bytes, fd, ld, lk, errs, tmo);
    tests++;
    if (tmo != 0 || fd !== 64'h0807060504030201 || ld !== 64'h100F0E0D0C0B0A09) begin
      fails++; $display("FAIL mode2_f1: first %h last %h tmo %0d expected 0807060504030201 / 100f0e0d0c0b0a09",
                        fd, ld, tmo);
    end
    do_reset();
    set_cfg(2'd1, 8'hA5, 12, 12, 8, 0);
    enable = 1'b1;
    get_frame(0, 0, dlen, beats, bytes, fd, ld, lk, errs, tmo);
    tests++;
    if (tmo != 0 || errs != 0 || beats != 2 || fd !== {8{8'hA5}} ||
        ld !== 64'h00000000A5A5A5A5 || lk !== 8'h0F) begin
      fails++; $display("FAIL mode1_fill: beats %0d first %h last %h keep %h expected 2 / a5.. / 00000000a5a5a5a5 / 0f",
                        beats, fd, ld, lk);
    end
  endtask

  task automatic test_limit();
    int exp_len [3] = '{64, 72, 80};
    int dlen, beats, bytes, errs, tmo;
    logic [DW-1:0] fd, ld;
    logic [KW-1:0] lk;
    do_reset();
    set_cfg(2'd0, 8'h00, 64, 80, 8, 3);
    enable = 1'b1;
    for (int f = 0; f < 3; f++) begin
      get_frame(0, 0, dlen, beats, bytes, fd, ld, lk, errs, tmo);
      tests++;
      if (tmo != 0 || dlen != exp_len[f]) begin
        fails++; $display("FAIL limit_len[%0d]: len %0d tmo %0d expected %0d", f, dlen, tmo, exp_len[f]);
      end
    end
    repeat (4) @(negedge clk);
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || frame_count !== 32'd3 || m_if.desc_valid !== 1'b0) begin
      fails++; $display("FAIL limit_stop: done %b busy %b count %0d desc_valid %b expected 1 0 3 0",
                        done, busy, frame_count, m_if.desc_valid);
    end
    enable = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (done !== 1'b0) begin
      fails++; $display("FAIL limit_done_clear: done %b expected 0", done);
    end
    enable = 1'b1;
    get_frame(0, 0, dlen, beats, bytes, fd, ld, lk, errs, tmo);
    tests++;
    if (tmo != 0 || dlen != 64) begin
      fails++; $display("FAIL limit_restart: len %0d tmo %0d expected 64", dlen, tmo);
    end
  endtask

  task automatic test_enable_drop();
    int dlen, beats, bytes, errs, tmo;
    logic [DW-1:0] fd, ld;
    logic [KW-1:0] lk;
    do_reset();
    set_cfg(2'd0, 8'h00, 64, 64, 8, 0);
    enable = 1'b1;
    get_frame(0, 2, dlen, beats, bytes, fd, ld, lk, errs, tmo);
    tests++;
    if (tmo != 0 || errs != 0 || beats != 8 || bytes != 64 || lk !== 8'hFF) begin
      fails++; $display("FAIL en_drop_frame: beats %0d bytes %0d keep %h errs %0d tmo %0d expected 8/64/ff",
                        beats, bytes, lk, errs, tmo);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || m_if.desc_valid !== 1'b0 || m_if.tvalid !== 1'b0 || frame_count !== 32'd1) begin
      fails++; $display("FAIL en_drop_idle: busy %b desc_valid %b tvalid %b count %0d expected 0 0 0 1",
                        busy, m_if.desc_valid, m_if.tvalid, frame_count);
    end
  endtask

  task automatic test_rst_mid();
    int seen;
    do_reset();
    set_cfg(2'd0, 8'h00, 64, 64, 8, 0);
    m_if.desc_ready = 1'b1;
    m_if.tready = 1'b1;
    enable = 1'b1;
    seen = 0;
    for (int i = 0; i < 50 && seen < 3; i++) begin
      @(negedge clk);
      if (m_if.tvalid) seen++;
    end
    tests++;
    if (seen < 3) begin
      fails++; $display("FAIL rst_mid_start: beats seen %0d expected 3", seen);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (m_if.tvalid !== 1'b0 || m_if.tlast !== 1'b0 || busy !== 1'b0 || m_if.desc_valid !== 1'b0) begin
      fails++; $display("FAIL rst_mid_abort: tvalid %b tlast %b busy %b desc_valid %b expected 0 0 0 0",
                        m_if.tvalid, m_if.tlast, busy, m_if.desc_valid);
    end
    rst = 1'b0;
    enable = 1'b0;
    m_if.desc_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_len_step();
    test_len61();
    test_stalls();
    test_modes();
    test_limit();
    test_enable_drop();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
